elevator_function_ctrl: RTL and testbench
=========================================

# elevator_function_ctrl

Single-car elevator controller for a 32-floor shaft, with cabin climate control. It latches hall and cabin call requests and serves them in SCAN order, holding direction while calls remain ahead. It drives the motor and door outputs from an externally supplied floor position, and runs hysteresis-based heater/cooler control from a signed temperature input. It sits between the shaft/plant model (position, temperature) and the actuators.

## Interface
Parameters:
- DOOR_CYCLES, 5: clock cycles the door stays open per stop (≥1).
- COOL_ON, 27 / COOL_OFF, 24: cooler switches on when temp ≥ COOL_ON and off when temp ≤ COOL_OFF.
- HEAT_ON, 17 / HEAT_OFF, 20: heater switches on when temp ≤ HEAT_ON and off when temp ≥ HEAT_OFF.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high; has priority over all other inputs.
- off_btn  in  1  level; while 1 the controller is in the OFF state.
- position  in  32  current cabin floor, unsigned binary; valid range 0–31.
- floor_press_event  in  32  hall calls; bit i = call at floor i.
- cabin_press_event  in  32  cabin buttons; bit i = request floor i.
- temp  in  32 signed  cabin temperature in °C.
- door  out  1  1 = door open.
- cooler  out  1  cooler enable.
- heater  out  1  heater enable.
- motor_up  out  1  drive cabin upward.
- motor_down  out  1  drive cabin downward.

## Operation
- pending[31:0]: each cycle, pending |= floor_press_event | cabin_press_event. Presses may be single-cycle pulses or held levels.
- The bit for the current floor is cleared on the edge that enters DOOR_OPEN, and on every cycle spent in DOOR_OPEN.
- above = |pending bits > position|; below = |pending bits < position|. last_dir register: 0 = up, 1 = down; reset value 0.
- IDLE:
  - pending[position] set → DOOR_OPEN.
  - else if last_dir = up and above → MOVE_UP.
  - else if below → MOVE_DOWN (last_dir = down).
  - else if above → MOVE_UP (last_dir = up).
  - else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - pending[position] set → DOOR_OPEN.
  - else if no call remains in the travel direction → IDLE.
  - else stay.
  - motor_up is 1 only in MOVE_UP; motor_down is 1 only in MOVE_DOWN.
- DOOR_OPEN:
  - door = 1; counter loads 0 on entry.
  - A new press for the current floor restarts the counter.
  - Counter reaching DOOR_CYCLES−1 → IDLE, door = 0.
- OFF:
  - Entered from any state when off_btn = 1.
  - door, motors, heater and cooler all 0; pending cleared; presses ignored.
  - off_btn = 0 → IDLE.
- Position > 31 is treated as "between floors": no floor match, and above/below are computed over all pending bits. In IDLE with an out-of-range position the controller takes no action.
- Climate: heater and cooler are independent hysteresis flags, evaluated every non-OFF cycle. If both on-conditions would hold (misconfigured thresholds), cooler wins and heater is forced to 0.
- Invariants:
  - motor_up & motor_down == 0.
  - door & (motor_up | motor_down) == 0.
  - heater & cooler == 0.

## Timing
- All outputs are registered; inputs are sampled on the rising edge, giving 1-cycle input-to-output latency.
- Reset state: IDLE, pending = 0, last_dir = up, counter = 0, all outputs 0.
- Stop at a floor: the same edge drops the motor and raises door.
- Door closes on the edge that enters IDLE. A motor cannot start before the following edge, so the door is closed for ≥1 cycle before any motion.
- Door-open duration is exactly DOOR_CYCLES cycles when no re-press occurs.
- Reset mid-motion or mid-door immediately forces the reset state. off_btn and reset asserted together → reset state.

## Structure
- Shared package elevator_pkg holds:
  - state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, OFF};
  - NUM_FLOORS = 32;
  - default thresholds and DOOR_CYCLES.
- One natural sub-module: elevator_climate (temp → heater/cooler hysteresis, with an enable input gated by OFF).
- The request register, above/below reduction and FSM stay in the top module.

## Test plan
- Reset held 3 cycles, then released with position = 0 and no presses → all outputs 0, stays IDLE.
- position = 0, cabin_press_event bit 3 pulsed → motor_up = 1 two cycles later. Step position to 3 → motor_up = 0, door = 1 for exactly 5 cycles, then idle.
- position = 5, last_dir = up, pending floors 2 and 8 → serves 8 first (motor_up), then 2 (motor_down).
- Press at the current floor during DOOR_OPEN → door period restarts; press at current floor while IDLE → door opens next cycle with no motor activity.
- off_btn = 1 while in MOVE_DOWN → motors 0 and pending cleared next cycle; presses ignored until release; release → IDLE with no pending calls.
- temp sweeps 16 → 30 → 16:
  - heater is 1 at 17, off at 20;
  - cooler is 1 at 27, off at 24;
  - both are never 1 together.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller.
// Provides the controller state encoding, travel direction encoding,
// the floor count and the default door/climate tuning values.
package elevator_pkg;

  localparam int NUM_FLOORS = 32;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  // Default tuning values (temperatures in degrees C, door time in cycles)
  localparam int DEF_DOOR_CYCLES = 5;
  localparam int DEF_COOL_ON     = 27;
  localparam int DEF_COOL_OFF    = 24;
  localparam int DEF_HEAT_ON     = 17;
  localparam int DEF_HEAT_OFF    = 20;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    OFF
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/elevator_climate.sv
// Cabin climate control: independent hysteresis flags for heater and cooler.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   enable       : 0 forces both actuators off and clears their state
//   temp         : signed cabin temperature in degrees C
//   heater       : registered heater enable
//   cooler       : registered cooler enable (wins over heater)
module elevator_climate
  import elevator_pkg::*;
#(
  parameter int COOL_ON  = DEF_COOL_ON,
  parameter int COOL_OFF = DEF_COOL_OFF,
  parameter int HEAT_ON  = DEF_HEAT_ON,
  parameter int HEAT_OFF = DEF_HEAT_OFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [31:0] temp,
  output logic               heater,
  output logic               cooler
);

  logic heat_q, heat_d;
  logic cool_q, cool_d;

  always_comb begin
    cool_d = cool_q;
    heat_d = heat_q;
    if (enable) begin
      if (temp >= COOL_ON) begin
        cool_d = 1'b1;
      end else if (temp <= COOL_OFF) begin
        cool_d = 1'b0;
      end
      if (temp <= HEAT_ON) begin
        heat_d = 1'b1;
      end else if (temp >= HEAT_OFF) begin
        heat_d = 1'b0;
      end
      // Overlapping thresholds must never run both actuators at once.
      if (cool_d) begin
        heat_d = 1'b0;
      end
    end else begin
      cool_d = 1'b0;
      heat_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      heat_q <= 1'b0;
      cool_q <= 1'b0;
    end else begin
      heat_q <= heat_d;
      cool_q <= cool_d;
    end
  end

  assign heater = heat_q;
  assign cooler = cool_q;

endmodule

// File: rtl/elevator_function_ctrl.sv
// Single-car elevator controller for a 32-floor shaft with climate control.
// Latches hall and cabin calls and serves them in SCAN order, holding the
// travel direction while calls remain ahead.
// Ports:
//   clock, reset         : system clock, synchronous active-high reset
//   off_btn              : level; controller is held OFF while high
//   position             : current cabin floor (values > 31 = between floors)
//   floor_press_event    : hall calls, one bit per floor
//   cabin_press_event    : cabin buttons, one bit per floor
//   temp                 : signed cabin temperature
//   door                 : door open
//   cooler, heater       : climate actuators
//   motor_up, motor_down : cabin drive
module elevator_function_ctrl
  import elevator_pkg::*;
#(
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int COOL_ON     = DEF_COOL_ON,
  parameter int COOL_OFF    = DEF_COOL_OFF,
  parameter int HEAT_ON     = DEF_HEAT_ON,
  parameter int HEAT_OFF    = DEF_HEAT_OFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  off_btn,
  input  logic [31:0]           position,
  input  logic [NUM_FLOORS-1:0] floor_press_event,
  input  logic [NUM_FLOORS-1:0] cabin_press_event,
  input  logic signed [31:0]    temp,
  output logic                  door,
  output logic                  cooler,
  output logic                  heater,
  output logic                  motor_up,
  output logic                  motor_down
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOOR_CYCLES - 1);

  state_t                  state_q, state_d;
  dir_t                    last_dir_q, last_dir_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    door_q, motor_up_q, motor_down_q;

  logic [NUM_FLOORS-1:0]   press_all;
  logic [NUM_FLOORS-1:0]   above_vec, below_vec;
  logic                    pos_valid;
  logic [FLOOR_W-1:0]      pos_idx;
  logic                    pos_match;
  logic                    press_here;
  logic                    above, below;

  assign press_all  = floor_press_event | cabin_press_event;
  assign pos_valid  = (position < 32'(NUM_FLOORS));
  assign pos_idx    = position[FLOOR_W-1:0];
  assign pos_match  = pos_valid && pending_q[pos_idx];
  assign press_here = pos_valid && press_all[pos_idx];

  // Between floors every pending call counts as both ahead and behind,
  // so a moving car keeps going until it reaches a real floor.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_dir_mask
      assign above_vec[gi] = pending_q[gi] && (!pos_valid || (32'(gi) > position));
      assign below_vec[gi] = pending_q[gi] && (!pos_valid || (32'(gi) < position));
    end
  endgenerate

  assign above = |above_vec;
  assign below = |below_vec;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;

    if (off_btn) begin
      state_d = OFF;
    end else begin
      case (state_q)
        IDLE: begin
          if (pos_match) begin
            state_d = DOOR_OPEN;
          end else if (pos_valid) begin
            if (last_dir_q == DIR_UP && above) begin
              state_d = MOVE_UP;
            end else if (below) begin
              state_d    = MOVE_DOWN;
              last_dir_d = DIR_DOWN;
            end else if (above) begin
              state_d    = MOVE_UP;
              last_dir_d = DIR_UP;
            end
          end
        end
        MOVE_UP: begin
          if (pos_match) begin
            state_d = DOOR_OPEN;
          end else if (!above) begin
            state_d = IDLE;
          end
        end
        MOVE_DOWN: begin
          if (pos_match) begin
            state_d = DOOR_OPEN;
          end else if (!below) begin
            state_d = IDLE;
          end
        end
        DOOR_OPEN: begin
          if (press_here) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        OFF: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (state_d == DOOR_OPEN && state_q != DOOR_OPEN) begin
      cnt_d = '0;
    end
    if (state_d == OFF) begin
      cnt_d = '0;
    end
  end

  // Request register: presses accumulate; the served floor is dropped on
  // every edge that leaves the car in DOOR_OPEN. Presses arriving in the
  // cycle OFF is released are ignored as well.
  always_comb begin
    pending_d = pending_q | press_all;
    if (state_q == OFF || state_d == OFF) begin
      pending_d = '0;
    end else if (state_d == DOOR_OPEN && pos_valid) begin
      pending_d[pos_idx] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_dir_q   <= DIR_UP;
      cnt_q        <= '0;
      pending_q    <= '0;
      door_q       <= 1'b0;
      motor_up_q   <= 1'b0;
      motor_down_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dir_q   <= last_dir_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      door_q       <= (state_d == DOOR_OPEN);
      motor_up_q   <= (state_d == MOVE_UP);
      motor_down_q <= (state_d == MOVE_DOWN);
    end
  end

  assign door       = door_q;
  assign motor_up   = motor_up_q;
  assign motor_down = motor_down_q;

  elevator_climate #(
    .COOL_ON  (COOL_ON),
    .COOL_OFF (COOL_OFF),
    .HEAT_ON  (HEAT_ON),
    .HEAT_OFF (HEAT_OFF)
  ) u_climate (
    .clock  (clock),
    .reset  (reset),
    .enable (state_d != OFF),
    .temp   (temp),
    .heater (heater),
    .cooler (cooler)
  );

endmodule

// File: tb/tb_elevator_function_ctrl.sv
// Directed testbench for elevator_function_ctrl.
// Output vector order: {door, cooler, heater, motor_up, motor_down}.
module tb_elevator_function_ctrl;

  logic               clock = 1'b0;
  logic               reset;
  logic               off_btn;
  logic [31:0]        position;
  logic [31:0]        floor_press_event;
  logic [31:0]        cabin_press_event;
  logic signed [31:0] temp;
  logic               door, cooler, heater, motor_up, motor_down;

  int errors = 0;
  int checks = 0;

  elevator_function_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .off_btn           (off_btn),
    .position          (position),
    .floor_press_event (floor_press_event),
    .cabin_press_event (cabin_press_event),
    .temp              (temp),
    .door              (door),
    .cooler            (cooler),
    .heater            (heater),
    .motor_up          (motor_up),
    .motor_down        (motor_down)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
    end else begin
      $display("ok   %s: %b", tag, got[4:0]);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, door, cooler, heater, motor_up, motor_down};
  endfunction

  // Advance one clock, sample 1 time unit after the edge, check invariants.
  task automatic tick();
    @(posedge clock);
    #1;
    if ((motor_up & motor_down) | (door & (motor_up | motor_down)) | (heater & cooler))
      check_val("invariant", outs(), 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset             = 1'b1;
    off_btn           = 1'b0;
    position          = 32'd0;
    floor_press_event = '0;
    cabin_press_event = '0;
    temp              = 32'sd22;

    // Reset held 3 cycles
    ticks(3);
    check_val("reset_state", outs(), 32'b00000);
    reset = 1'b0;
    ticks(2);
    check_val("idle_after_reset", outs(), 32'b00000);

    // Cabin call to floor 3 from floor 0
    cabin_press_event = 32'd1 << 3;
    tick();
    cabin_press_event = '0;
    check_val("call3_latched", outs(), 32'b00000);
    tick();
    check_val("call3_motor_up", outs(), 32'b00010);
    position = 32'd1; tick();
    check_val("pass_floor1", outs(), 32'b00010);
    position = 32'd2; tick();
    check_val("pass_floor2", outs(), 32'b00010);
    position = 32'd3; tick();
    check_val("stop3_door_c1", outs(), 32'b10000);
    for (int i = 2; i <= 5; i++) begin
      tick();
      check_val($sformatf("stop3_door_c%0d", i), outs(), 32'b10000);
    end
    tick();
    check_val("stop3_door_closed", outs(), 32'b00000);
    tick();
    check_val("stop3_idle", outs(), 32'b00000);

    // SCAN: at floor 5 heading up, calls at 2 and 8 -> 8 first
    position = 32'd5;
    floor_press_event = (32'd1 << 2) | (32'd1 << 8);
    tick();
    floor_press_event = '0;
    tick();
    check_val("scan_up_first", outs(), 32'b00010);
    tick();
    check_val("scan_hold_up", outs(), 32'b00010);
    position = 32'd8; tick();
    check_val("scan_stop8", outs(), 32'b10000);
    ticks(4);
    check_val("scan_door8_last", outs(), 32'b10000);
    tick();
    check_val("scan_close8", outs(), 32'b00000);
    tick();
    check_val("scan_down_second", outs(), 32'b00001);
    position = 32'd2; tick();
    check_val("scan_stop2", outs(), 32'b10000);
    ticks(5);
    check_val("scan_close2", outs(), 32'b00000);

    // Press at current floor while idle, then re-press while door open
    cabin_press_event = 32'd1 << 2;
    tick();
    cabin_press_event = '0;
    check_val("here_press_latched", outs(), 32'b00000);
    tick();
    check_val("here_door_open", outs(), 32'b10000);
    ticks(2);
    cabin_press_event = 32'd1 << 2;
    tick();
    cabin_press_event = '0;
    check_val("repress_door", outs(), 32'b10000);
    ticks(4);
    check_val("repress_extended", outs(), 32'b10000);
    tick();
    check_val("repress_closed", outs(), 32'b00000);

    // OFF while moving down (cooler running too)
    position = 32'd10;
    temp = 32'sd30;
    floor_press_event = (32'd1 << 4) | (32'd1 << 20);
    tick();
    floor_press_event = '0;
    check_val("off_pre_cooler", outs(), 32'b01000);
    tick();
    check_val("off_pre_down", outs(), 32'b01001);
    off_btn = 1'b1;
    tick();
    check_val("off_all_zero", outs(), 32'b00000);
    cabin_press_event = 32'd1 << 10;
    tick();
    cabin_press_event = '0;
    check_val("off_press_ignored", outs(), 32'b00000);
    temp = 32'sd22;
    off_btn = 1'b0;
    tick();
    check_val("off_release_idle", outs(), 32'b00000);
    ticks(3);
    check_val("off_pending_cleared", outs(), 32'b00000);

    // Temperature sweep 16 -> 30 -> 16
    for (int t = 16; t <= 30; t++) begin
      temp = t;
      tick();
      check_val($sformatf("sweep_up_%0d", t), outs(),
                {27'd0, 1'b0, (t >= 27) ? 1'b1 : 1'b0, (t < 20) ? 1'b1 : 1'b0, 2'b00});
    end
    for (int t = 29; t >= 16; t--) begin
      temp = t;
      tick();
      check_val($sformatf("sweep_dn_%0d", t), outs(),
                {27'd0, 1'b0, (t > 24) ? 1'b1 : 1'b0, (t <= 17) ? 1'b1 : 1'b0, 2'b00});
    end
    temp = 32'sd22;
    tick();
    check_val("sweep_neutral", outs(), 32'b00000);

    // Out-of-range position: idle takes no action
    position = 32'd40;
    floor_press_event = 32'd1 << 3;
    tick();
    floor_press_event = '0;
    ticks(2);
    check_val("oor_no_action", outs(), 32'b00000);
    position = 32'd10;
    tick();
    check_val("oor_then_down", outs(), 32'b00001);

    // Reset together with off_btn mid-motion
    reset = 1'b1;
    off_btn = 1'b1;
    tick();
    check_val("reset_mid_motion", outs(), 32'b00000);
    reset = 1'b0;
    off_btn = 1'b0;
    ticks(2);
    check_val("reset_cleared_calls", outs(), 32'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
